// File: rtl/pdm_mic_ctrl.sv
// PDM microphone front end: divided PDM clock, bit capture/strobe to a CIC, warm-up/settle sequencing, 1-deep PCM output slot.
// Latency: pdm_bit/pdm_strobe one clk after the falling pdm_clk decision; pcm_valid one clk after cic_valid. No backpressure: a full, unaccepted slot drops the new sample and sets overrun.
module pdm_mic_ctrl #(
  parameter int PCM_W          = 24,
  parameter int DIV_W          = 8,
  parameter int WARMUP_PERIODS = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [3:0]       settle_cnt,
  input  logic             pdm_data,
  output logic             pdm_clk,
  output logic             pdm_bit,
  output logic             pdm_strobe,
  output logic             cic_rst,
  input  logic [PCM_W-1:0] cic_pcm,
  input  logic             cic_valid,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             overrun,
  input  logic             clear_overrun,
  output logic [1:0]       state
);

  localparam int WW = $clog2(WARMUP_PERIODS + 1);
  localparam logic [WW-1:0]    WARM_LAST = WW'(WARMUP_PERIODS - 1);
  localparam logic [WW-1:0]    WARM_ONE  = WW'(1);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_SETTLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DIV_W-1:0]   r_half;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [3:0]         r_settle;
  logic [3:0]         r_settle_seen;
  logic [WW-1:0]      r_warm_cnt;
  logic               r_pdm_clk;
  logic               r_pdm_bit;
  logic               r_pdm_strobe;
  logic [PCM_W-1:0]   r_pcm_data;
  logic               r_pcm_valid;
  logic               r_overrun;

  logic w_active;
  logic w_toggle;
  logic w_warm_done;
  logic w_settle_done;
  logic w_in_run;
  logic w_ovr_evt;

  assign w_active      = (r_state != S_IDLE) && enable;
  assign w_toggle      = w_active && (r_div_cnt == r_half - DIV_ONE);
  assign w_warm_done   = r_pdm_strobe && (r_warm_cnt == WARM_LAST);
  assign w_settle_done = (r_settle == 4'd0) || (cic_valid && (r_settle_seen + 4'd1 == r_settle));
  assign w_in_run      = w_active && (r_state == S_RUN);
  assign w_ovr_evt     = w_in_run && cic_valid && r_pcm_valid && !pcm_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (enable) w_next = S_WARMUP;
      S_WARMUP: if (!enable) w_next = S_IDLE; else if (w_warm_done) w_next = S_SETTLE;
      S_SETTLE: if (!enable) w_next = S_IDLE; else if (w_settle_done) w_next = S_RUN;
      S_RUN:    if (!enable) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_half        <= '0;
      r_div_cnt     <= '0;
      r_settle      <= '0;
      r_settle_seen <= '0;
      r_warm_cnt    <= '0;
      r_pdm_clk     <= 1'b0;
      r_pdm_bit     <= 1'b0;
      r_pdm_strobe  <= 1'b0;
      r_pcm_data    <= '0;
      r_pcm_valid   <= 1'b0;
    end else begin
      r_pdm_strobe <= 1'b0;
      if (!w_active) begin
        r_div_cnt     <= '0;
        r_pdm_clk     <= 1'b0;
        r_warm_cnt    <= '0;
        r_settle_seen <= '0;
        r_pcm_valid   <= 1'b0;
        // Divider and settle config are frozen for the whole session once leaving IDLE.
        if (r_state == S_IDLE && enable) begin
          r_half   <= (clk_div == '0) ? DIV_ONE : clk_div;
          r_settle <= settle_cnt;
        end
      end else begin
        if (w_toggle) begin
          r_div_cnt <= '0;
          r_pdm_clk <= ~r_pdm_clk;
          if (r_pdm_clk) begin
            r_pdm_bit    <= pdm_data;
            r_pdm_strobe <= 1'b1;
          end
        end else begin
          r_div_cnt <= r_div_cnt + DIV_ONE;
        end
        if (r_state == S_WARMUP && r_pdm_strobe) r_warm_cnt <= r_warm_cnt + WARM_ONE;
        if (r_state == S_SETTLE && cic_valid) r_settle_seen <= r_settle_seen + 4'd1;
        if (w_in_run) begin
          if (cic_valid && (!r_pcm_valid || pcm_ready)) begin
            r_pcm_data  <= cic_pcm;
            r_pcm_valid <= 1'b1;
          end else if (r_pcm_valid && pcm_ready) begin
            r_pcm_valid <= 1'b0;
          end
        end
      end
    end
  end

  // Overrun survives a stop; only clear_overrun or reset removes it, and a new loss beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_overrun <= 1'b0;
    else if (w_ovr_evt)     r_overrun <= 1'b1;
    else if (clear_overrun) r_overrun <= 1'b0;
  end

  assign pdm_clk    = r_pdm_clk;
  assign pdm_bit    = r_pdm_bit;
  assign pdm_strobe = r_pdm_strobe;
  assign cic_rst    = (r_state == S_IDLE) || (r_state == S_WARMUP);
  assign pcm_data   = r_pcm_data;
  assign pcm_valid  = r_pcm_valid;
  assign overrun    = r_overrun;
  assign state      = r_state;

endmodule
